average_read_control: RTL and testbench

AVERAGE_READ_CONTROL -- requirements
Module: average_read_control

---
 rtl/average_read_control.sv | 137 +++++++++++++
 tb/tb_average_read_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/average_read_control.sv
// Streams the 16-lane average buffer out as six 3-lane groups (opcodes 32..37).
// Define AVG_READ_CAPTURE_EN to snapshot the buffer on start instead of reading it live.
module average_read_control #(
  parameter int DATA_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [16*DATA_W-1:0] i_avgData,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [5:0]           o_opcode,
  output logic [15:0]          o_selRead,
  output logic [3*DATA_W-1:0]  o_data,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t state, state_n;
  logic [2:0] g, g_n;
  logic [16*DATA_W-1:0] src;
  logic [DATA_W-1:0] lane [16];
  logic [3:0] base;
  logic [3*DATA_W-1:0] grp;
  logic [15:0] sel;

`ifdef AVG_READ_CAPTURE_EN
  logic [16*DATA_W-1:0] snap;

  // Freeze the buffer when a readout is accepted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      snap <= '0;
    end else if (state == IDLE && i_start) begin
      snap <= i_avgData;
    end
  end

  assign src = snap;
`else
  assign src = i_avgData;
`endif

  // State and group counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      g     <= '0;
    end else begin
      state <= state_n;
      g     <= g_n;
    end
  end

  // Split the flat buffer into lanes
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      lane[k] = src[k*DATA_W +: DATA_W];
    end
  end

  // Pick the lanes of the current group; the last group holds lane 15 alone
  always_comb begin
    base = 4'(g) * 4'd3;
    if (g == 3'd5) begin
      grp = {{(2*DATA_W){1'b0}}, lane[15]};
    end else begin
      grp = {lane[base+4'd2], lane[base+4'd1], lane[base]};
    end
  end

  // Lane mask of the current group
  always_comb begin
    sel = '0;
    unique case (g)
      3'd0: sel = 16'h0007;
      3'd1: sel = 16'h0038;
      3'd2: sel = 16'h01C0;
      3'd3: sel = 16'h0E00;
      3'd4: sel = 16'h7000;
      3'd5: sel = 16'h8000;
      default: sel = '0;
    endcase
  end

  // Next state and outputs; everything is zero outside SEND/DONE
  always_comb begin
    state_n   = state;
    g_n       = g;
    o_valid   = 1'b0;
    o_opcode  = '0;
    o_selRead = '0;
    o_data    = '0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      IDLE: begin
        g_n = '0;
        if (i_start) begin
          state_n = SEND;
        end
      end
      SEND: begin
        o_valid   = 1'b1;
        o_busy    = 1'b1;
        o_opcode  = 6'd32 + 6'(g);
        o_selRead = sel;
        o_data    = grp;
        if (i_ready) begin
          if (g == 3'd5) begin
            state_n = DONE;
            g_n     = '0;
          end else begin
            g_n = g + 3'd1;
          end
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_n = IDLE;
        g_n     = '0;
      end
      default: begin
        state_n = IDLE;
        g_n     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_average_read_control.sv
// Bench for average_read_control: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the readout.
module tb_average_read_control;

  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_start = 1'b0;
  logic [16*W-1:0] i_avgData = '0;
  logic           i_ready = 1'b0;
  logic           o_valid;
  logic [5:0]     o_opcode;
  logic [15:0]    o_selRead;
  logic [3*W-1:0] o_data;
  logic           o_busy;
  logic           o_done;

  average_read_control #(.DATA_W(W)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_avgData (i_avgData),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_opcode  (o_opcode),
    .o_selRead (o_selRead),
    .o_data    (o_data),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total = 0;
  int failed = 0;

  // model: an active readout walks groups 0..5, then one done cycle
  bit m_act = 0;
  bit m_done = 0;
  int m_grp = 0;
  logic [16*W-1:0] m_snap = '0;
  int cyc_n = 0;
  int done_cyc = -1;
  int dut_dones = 0;
  int mdl_dones = 0;
  logic [3*W-1:0] last_g5 = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*W-1:0] exp_data(input int grp,
                                               input logic [16*W-1:0] s);
    logic [3*W-1:0] r = '0;
    for (int k = 0; k < 3; k++) begin
      if (3*grp + k < 16) r[k*W +: W] = s[(3*grp+k)*W +: W];
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_sel(input int grp);
    logic [15:0] r = '0;
    for (int k = 0; k < 3; k++) begin
      if (3*grp + k < 16) r[3*grp+k] = 1'b1;
    end
    return r;
  endfunction

  // one clock cycle: apply inputs, check outputs, advance the model
  task automatic cyc(input bit st, input bit rdy);
    logic [16*W-1:0] s;
    i_start = st;
    i_ready = rdy;
    #1;
`ifdef AVG_READ_CAPTURE_EN
    s = m_snap;
`else
    s = i_avgData;
`endif
    if (m_act) begin
      chk("valid", 32'(o_valid), 1);
      chk("busy", 32'(o_busy), 1);
      chk("done", 32'(o_done), 0);
      chk("opcode", 32'(o_opcode), 32'(32 + m_grp));
      chk("sel", 32'(o_selRead), 32'(exp_sel(m_grp)));
      chk("data", 32'(o_data), 32'(exp_data(m_grp, s)));
    end else begin
      chk("valid", 32'(o_valid), 0);
      chk("busy", 32'(o_busy), 32'(m_done));
      chk("done", 32'(o_done), 32'(m_done));
      chk("opcode", 32'(o_opcode), 0);
      chk("sel", 32'(o_selRead), 0);
      chk("data", 32'(o_data), 0);
    end
    if (o_done) begin
      dut_dones++;
      done_cyc = cyc_n;
    end
    if (o_valid && o_opcode == 6'd37) last_g5 = o_data;
    if (m_act) begin
      if (rdy) begin
        if (m_grp == 5) begin
          m_act = 0;
          m_done = 1;
        end else begin
          m_grp++;
        end
      end
    end else if (m_done) begin
      m_done = 0;
      mdl_dones++;
    end else if (st) begin
      m_act = 1;
      m_grp = 0;
      m_snap = i_avgData;
    end
    @(posedge i_clk);
    #1;
    cyc_n++;
  endtask

  function automatic logic [16*W-1:0] ramp();
    logic [16*W-1:0] r;
    for (int k = 0; k < 16; k++) r[k*W +: W] = W'(k + 1);
    return r;
  endfunction

  initial begin
    int st_cyc;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_data", 32'(o_data), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // full readout with ready held high, incrementing lanes
    i_avgData = ramp();
    st_cyc = cyc_n;
    cyc(1, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1);
    // start cycle counted as cycle 1, so done lands in cycle 8
    chk("latency", 32'(done_cyc - st_cyc + 1), 8);
    chk("g5_ramp", 32'(last_g5), 32'h000010);

    // stall three cycles on group 2
    cyc(1, 1);
    cyc(0, 1);
    cyc(0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    chk("stall_op", 32'(o_opcode), 34);
    for (int i = 0; i < 6; i++) cyc(0, 1);

    // restart request during group 1 is ignored
    cyc(1, 1);
    cyc(0, 1);
    cyc(1, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1);

    // asynchronous reset during group 3
    cyc(1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1);
    chk("pre_rst_op", 32'(o_opcode), 35);
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_sel", 32'(o_selRead), 0);
    m_act = 0;
    m_done = 0;
    @(posedge i_clk);
    #1;
    chk("rst_hold_done", 32'(o_done), 0);
    i_rst = 1'b0;
    cyc(0, 1);
    cyc(0, 1);
    cyc(1, 1);
    chk("restart_op", 32'(o_opcode), 32);
    for (int i = 0; i < 8; i++) cyc(0, 1);

    // lane 15 changes after start
    i_avgData = ramp();
    cyc(1, 1);
    i_avgData[15*W +: W] = 8'hAA;
    for (int i = 0; i < 8; i++) cyc(0, 1);
`ifdef AVG_READ_CAPTURE_EN
    chk("g5_live", 32'(last_g5), 32'h000010);
`else
    chk("g5_live", 32'(last_g5), 32'h0000AA);
`endif

    // start held high: back-to-back readouts
    for (int i = 0; i < 24; i++) cyc(1, 1);
    cyc(0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1);

    // random traffic and data
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++) i_avgData[k*32 +: 32] = $urandom;
      end
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 30; i++) cyc(0, 1);
    chk("done_count", 32'(dut_dones), 32'(mdl_dones));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
